// File: rtl/mdr_mem_if.sv
//============================================================================
// Module  : mdr_mem_if
// Purpose : Memory data register with a single-beat memory handshake engine,
//           sub-word sizing, sign/zero extension and a bounded-wait timeout.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module mdr_mem_if #(
    parameter int DATA_W     = 32,
    parameter int TMO_CYCLES = 16,
    parameter int TMO_W      = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MDRin,
    input  logic [DATA_W-1:0] busMuxOut,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ERR     = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TMO_CYCLES - 1);

    state_t           r_state;
    logic [TMO_W-1:0] r_cnt;
    logic [1:0]       r_size;
    logic             r_sext;

    // Sub-word reads take the low lane; the fill bit is the lane's MSB only when signed.
    function automatic logic [DATA_W-1:0] fmt_rd(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        sz,
                                                 input logic              sx);
        logic [DATA_W-1:0] v;
        case (sz)
            2'b00: begin
                v       = {DATA_W{sx & d[7]}};
                v[7:0]  = d[7:0];
            end
            2'b01: begin
                v       = {DATA_W{sx & d[15]}};
                v[15:0] = d[15:0];
            end
            default: v = d;
        endcase
        return v;
    endfunction

    // Writes replicate the sub-word across every lane so any byte/half address hits.
    function automatic logic [DATA_W-1:0] fmt_wr(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        sz);
        logic [DATA_W-1:0] v;
        case (sz)
            2'b00:   v = {(DATA_W/8){d[7:0]}};
            2'b01:   v = {(DATA_W/16){d[15:0]}};
            default: v = d;
        endcase
        return v;
    endfunction

    assign busy = (r_state == RD_WAIT) || (r_state == WR_WAIT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_size    <= 2'b00;
            r_sext    <= 1'b0;
            q         <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rd_req) begin
                        r_size  <= size;
                        r_sext  <= sign_ext;
                        r_cnt   <= '0;
                        mem_rd  <= 1'b1;
                        r_state <= RD_WAIT;
                    end else if (wr_req) begin
                        r_size    <= size;
                        r_cnt     <= '0;
                        mem_wdata <= fmt_wr(q, size);
                        mem_wr    <= 1'b1;
                        r_state   <= WR_WAIT;
                    end else if (MDRin) begin
                        q <= busMuxOut;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // Ready wins over timeout so the last allowed wait cycle still completes.
                    if (mem_ready) begin
                        if (r_state == RD_WAIT) begin
                            q <= fmt_rd(mem_rdata, r_size, r_sext);
                        end
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_cnt == c_tmo_last) begin
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        err     <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        err     <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdr_mem_if.sv
//============================================================================
// Module  : tb_mdr_mem_if
// Purpose : Scoreboard bench for mdr_mem_if: directed transactions push
//           expectations, a negedge monitor pops them on done/err.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mdr_mem_if;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic              MDRin = 1'b0;
    logic [DATA_W-1:0] busMuxOut = '0;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              mem_rd, mem_wr, busy, done, err;
    logic [DATA_W-1:0] mem_wdata, q;

    mdr_mem_if #(.DATA_W(DATA_W), .TMO_CYCLES(16), .TMO_W(5)) dut (
        .clk(clk), .clr(clr), .MDRin(MDRin), .busMuxOut(busMuxOut),
        .rd_req(rd_req), .wr_req(wr_req), .size(size), .sign_ext(sign_ext),
        .err_clr(err_clr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .q(q),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] wd;
        bit          chk_wd;
        int          nrd;
        int          nwr;
        bit          is_err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: strobe cycles are counted per transaction and checked at its end.
    initial begin : monitor
        int   crd;
        int   cwr;
        bit   perr;
        exp_t e;
        crd = 0; cwr = 0; perr = 0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                crd = 0; cwr = 0; perr = 0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected: got done=1 want no pending transaction");
                    end else begin
                        e = sb.pop_front();
                        chk("done_err_flag", {31'b0, err}, {31'b0, e.is_err});
                        chk("done_q", q, e.q);
                        if (e.chk_wd) chk("done_wdata", mem_wdata, e.wd);
                        chk("done_nrd", crd, e.nrd);
                        chk("done_nwr", cwr, e.nwr);
                    end
                    crd = 0; cwr = 0;
                end
                if (err && !perr) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL err_unexpected: got err=1 want no pending transaction");
                    end else begin
                        e = sb.pop_front();
                        chk("err_done_flag", {31'b0, done}, {31'b0, ~e.is_err});
                        chk("err_q", q, e.q);
                        chk("err_nrd", crd, e.nrd);
                        chk("err_nwr", cwr, e.nwr);
                    end
                    crd = 0; cwr = 0;
                end
                perr = err;
                if (mem_rd) crd++;
                if (mem_wr) cwr++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic load(input logic [31:0] v);
        MDRin = 1'b1; busMuxOut = v;
        tick();
        MDRin = 1'b0;
        chk("load_q", q, v);
    endtask

    task automatic do_read(input logic [1:0] sz, input logic sx, input int n,
                           input logic [31:0] rdata, input logic [31:0] expq, input bit both);
        exp_t e;
        e.q = expq; e.wd = '0; e.chk_wd = 0; e.nrd = n; e.nwr = 0; e.is_err = 0;
        sb.push_back(e);
        rd_req = 1'b1; wr_req = both; size = sz; sign_ext = sx;
        tick();
        rd_req = 1'b0; wr_req = 1'b0; mem_rdata = rdata;
        repeat (n - 1) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wait_empty("read");
    endtask

    task automatic do_write(input logic [1:0] sz, input int n,
                            input logic [31:0] expwd, input logic [31:0] expq);
        exp_t e;
        e.q = expq; e.wd = expwd; e.chk_wd = 1; e.nrd = 0; e.nwr = n; e.is_err = 0;
        sb.push_back(e);
        wr_req = 1'b1; size = sz;
        tick();
        wr_req = 1'b0;
        repeat (n - 1) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wait_empty("write");
    endtask

    initial begin : stim
        exp_t e;
        repeat (2) tick();
        chk("rst_q", q, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_flags", {27'b0, mem_rd, mem_wr, busy, done, err}, 32'h0);
        clr = 1'b1;
        tick();

        load(32'hDEADBEEF);
        chk("load_idle", {29'b0, busy, mem_rd, mem_wr}, 32'h0);

        do_read(2'b00, 1'b1, 3, 32'h12345680, 32'hFFFFFF80, 0);
        do_read(2'b01, 1'b0, 3, 32'hAAAA8001, 32'h00008001, 0);
        do_read(2'b00, 1'b0, 1, 32'hABCDEFF0, 32'h000000F0, 0);

        load(32'h000000A5);
        do_write(2'b00, 1, 32'hA5A5A5A5, 32'h000000A5);
        load(32'h56781234);
        do_write(2'b01, 2, 32'h12341234, 32'h56781234);
        do_write(2'b10, 1, 32'h56781234, 32'h56781234);

        // Timeout: no ready, 16 strobe cycles then ERR.
        e.q = 32'h56781234; e.wd = '0; e.chk_wd = 0; e.nrd = 16; e.nwr = 0; e.is_err = 1;
        sb.push_back(e);
        rd_req = 1'b1; size = 2'b10;
        tick();
        rd_req = 1'b0;
        wait_empty("timeout");
        chk("tmo_err", {31'b0, err}, 32'h1);
        chk("tmo_busy", {31'b0, busy}, 32'h0);
        rd_req = 1'b1; MDRin = 1'b1; busMuxOut = 32'h0;
        tick();
        rd_req = 1'b0; MDRin = 1'b0;
        tick();
        chk("err_ignore", {29'b0, mem_rd, busy, err}, 32'h1);
        chk("err_q_hold", q, 32'h56781234);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("errclr_flags", {30'b0, err, busy}, 32'h0);
        do_read(2'b10, 1'b0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 0);

        // Ready on the last tolerated wait cycle.
        do_read(2'b01, 1'b1, 16, 32'h00017FFF, 32'h00007FFF, 0);
        chk("bound_no_err", {31'b0, err}, 32'h0);

        // Async reset mid-RD_WAIT.
        rd_req = 1'b1; size = 2'b10;
        tick();
        rd_req = 1'b0;
        tick(); tick();
        chk("mid_rd_active", {30'b0, mem_rd, busy}, 32'h3);
        #2 clr = 1'b0;
        #1;
        chk("arst_q", q, 32'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_flags", {27'b0, mem_rd, mem_wr, busy, done, err}, 32'h0);
        tick();
        clr = 1'b1;
        tick();

        load(32'h11111111);
        do_read(2'b10, 1'b0, 2, 32'h87654321, 32'h87654321, 1);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
Parametrised memory data register with a built-in memory handshake engine. It holds the CPU-side data word, loads it from the internal bus, and runs single-beat memory reads and writes with wait states, sub-word sizing (byte/half/word), sign or zero extension, and a bounded-wait timeout with a sticky error flag. It sits between the datapath bus and the external memory port.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 16 and at least 16
TMO_CYCLES, 16, maximum wait-state cycles per transaction before timeout; must be at least 1
TMO_W, 5, width of the timeout counter; must satisfy 2^TMO_W > TMO_CYCLES

Ports:
clk  input  1  system clock, rising-edge
clr  input  1  asynchronous active-low reset
MDRin  input  1  load q from busMuxOut (IDLE only)
busMuxOut  input  DATA_W  internal bus data
rd_req  input  1  start memory read
wr_req  input  1  start memory write of q
size  input  2  00 byte, 01 half, 10/11 word; sampled at request
sign_ext  input  1  1 = sign-extend sub-word reads; sampled at request
err_clr  input  1  clears err and leaves ERR state
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completes the current access
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
mem_wdata  output  DATA_W  lane-replicated write data
q  output  DATA_W  register contents
busy  output  1  high in RD_WAIT or WR_WAIT
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky timeout flag

Behaviour:
- Reset (clr=0, async): state IDLE; q, mem_rd, mem_wr, mem_wdata, done, err, and the counter all 0. Reset during a wait state drops mem_rd and mem_wr immediately.
- All outputs are registered. busy is decoded from state.
- States: IDLE, RD_WAIT, WR_WAIT, ERR.
- IDLE, priority rd_req > wr_req > MDRin:
  - rd_req: latch size and sign_ext; go to RD_WAIT; mem_rd=1 from the next cycle; counter=0.
  - wr_req: latch size; mem_wdata <= formatted q; go to WR_WAIT; mem_wr=1 from the next cycle; counter=0.
  - MDRin only: q <= busMuxOut (1-cycle latency, raw, no formatting).
- RD_WAIT / WR_WAIT:
  - mem_ready is checked first. If mem_ready=1: on a read, q <= formatted mem_rdata. Drop the strobe, pulse done for 1 cycle, go to IDLE.
  - Else if counter == TMO_CYCLES-1: drop the strobe, err <= 1, go to ERR; q unchanged.
  - Else: counter <= counter+1.
  - A transaction therefore tolerates exactly TMO_CYCLES wait cycles (ready on the TMO_CYCLES-th strobe cycle still succeeds).
- In wait states, MDRin, rd_req, wr_req, size, sign_ext, and err_clr are ignored. mem_ready outside wait states is ignored.
- ERR: no strobes. Requests and MDRin are ignored. err_clr=1 clears err and returns to IDLE on the next edge.
- Read formatting:
  - byte: mem_rdata[7:0], extended to DATA_W.
  - half: mem_rdata[15:0], extended to DATA_W.
  - word: mem_rdata unchanged.
  - Extension is bit 7 / bit 15 when the latched sign_ext=1, zeros otherwise.
- Write formatting:
  - byte: q[7:0] replicated DATA_W/8 times.
  - half: q[15:0] replicated DATA_W/16 times.
  - word: q unchanged.
- done is high only on the cycle immediately after the completing edge. A new request may be accepted on that same cycle (back-to-back).
- rd_req and wr_req together: the read wins and the write is dropped, not queued.

Test Plan:
- Reset, then MDRin=1, busMuxOut=0xDEADBEEF -> q=0xDEADBEEF next cycle; busy=0, mem_rd=0, mem_wr=0.
- rd_req with size=00, sign_ext=1; mem_ready after 3 wait cycles with mem_rdata=0x12345680 -> mem_rd high 3 cycles then drops; q=0xFFFFFF80; done pulses once.
- Same read with sign_ext=0 and size=01, mem_rdata=0xAAAA8001 -> q=0x00008001.
- q=0x000000A5, wr_req with size=00, mem_ready on the first wait cycle -> mem_wdata=0xA5A5A5A5; mem_wr high exactly 1 cycle; done pulses; q unchanged.
- rd_req with mem_ready held 0 -> mem_rd high exactly TMO_CYCLES (16) cycles, then err=1 and state ERR. A later rd_req is ignored. err_clr -> err=0 and IDLE; a subsequent read succeeds.
- Timeout boundary and reset:
  - mem_ready asserted on wait cycle 16 -> success with no err.
  - clr pulsed low mid-RD_WAIT -> mem_rd=0 immediately and all outputs 0.
  - rd_req and wr_req together -> read only.
